// File: rtl/riscv_lsu.sv
// riscv_lsu: request/acknowledge load/store unit with lane steering, load extension, misalign detection and bus timeout
module riscv_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_misalign,
    output logic                busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic                mem_err,
    input  logic [XLEN-1:0]     mem_rdata
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [LW-1:0] lane, lane_q;
    logic [2:0] f3_q;
    logic [1:0] sz;
    logic illegal, misalign, timeout;
    logic [7:0] mask;
    logic [XLEN-1:0] wrep, sh, ld;
    assign req_ready = state == IDLE;
    assign busy = state != IDLE;
    assign lane = req_addr[LW-1:0];
    assign sz = req_funct3[1:0];
    assign timeout = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    always_comb begin
        illegal = req_we ? (req_funct3[2] || (XLEN == 32 && req_funct3 == 3'b011))
                         : (req_funct3 == 3'b111 || (XLEN == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110)));
        misalign = sz == 2'd1 ? req_addr[0] : sz == 2'd2 ? |req_addr[1:0] : sz == 2'd3 ? |req_addr[2:0] : 1'b0;
        mask = sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;
        wrep = sz == 2'd0 ? {NB{req_wdata[7:0]}} : sz == 2'd1 ? {(NB/2){req_wdata[15:0]}}
             : sz == 2'd2 ? {(NB/4){req_wdata[31:0]}} : req_wdata;
        sh = mem_rdata >> {lane_q, 3'b000};
        ld = f3_q[1:0] == 2'd0 ? (f3_q[2] ? XLEN'(sh[7:0]) : XLEN'($signed(sh[7:0])))
           : f3_q[1:0] == 2'd1 ? (f3_q[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0])))
           : f3_q[1:0] == 2'd2 ? (f3_q[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0])))
           : sh;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lane_q       <= '0;
            f3_q         <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_misalign <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
        end else begin
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_misalign <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    if (illegal || misalign) begin
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_err      <= illegal;
                        rsp_misalign <= !illegal;
                    end else begin
                        state     <= BUS;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[ADDR_W-1:LW], LW'(0)};
                        mem_be    <= req_we ? NB'(mask << lane) : '1;
                        mem_wdata <= req_we ? wrep : '0;
                        lane_q    <= lane;
                        f3_q      <= req_funct3;
                    end
                end
                // an ack on the timeout edge still completes normally
                BUS: if (mem_ack) begin
                    state     <= RESP;
                    mem_req   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= mem_err;
                    rsp_rdata <= (mem_we || mem_err) ? '0 : ld;
                end else if (timeout) begin
                    state     <= RESP;
                    mem_req   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: scoreboarded directed bench for a 32-bit (TIMEOUT=4) and a 64-bit riscv_lsu
module tb_riscv_lsu;
    logic clock = 1'b0, reset = 1'b0;
    logic rv32 = 1'b0, rv64 = 1'b0, ack32 = 1'b0, ack64 = 1'b0, r_we = 1'b0, m_err = 1'b0, sel = 1'b0;
    logic [2:0] r_f3 = '0;
    logic [31:0] r_addr = '0;
    logic [63:0] r_wd = '0, m_rd = '0;
    logic rdy32, rspv32, err32, mis32, busy32, mreq32, mwe32;
    logic [31:0] maddr32, rdata32, mwd32;
    logic [3:0] be32;
    logic rdy64, rspv64, err64, mis64, busy64, mreq64, mwe64;
    logic [31:0] maddr64;
    logic [63:0] rdata64, mwd64;
    logic [7:0] be64;
    logic c_req, c_rdy, c_rspv, c_busy, c_we;
    logic [31:0] c_addr;
    logic [7:0] c_be;
    logic [63:0] c_wd;
    typedef struct packed {logic [63:0] rd; logic err; logic mis;} rsp_t;
    rsp_t q32[$], q64[$];
    int checks = 0, errors = 0, cyc = 0;
    int acc[$];

    riscv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
        .clock(clock), .reset(reset), .req_valid(rv32), .req_ready(rdy32), .req_we(r_we),
        .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wd[31:0]), .rsp_valid(rspv32),
        .rsp_rdata(rdata32), .rsp_err(err32), .rsp_misalign(mis32), .busy(busy32),
        .mem_req(mreq32), .mem_we(mwe32), .mem_addr(maddr32), .mem_be(be32), .mem_wdata(mwd32),
        .mem_ack(ack32), .mem_err(m_err), .mem_rdata(m_rd[31:0]));

    riscv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) u64 (
        .clock(clock), .reset(reset), .req_valid(rv64), .req_ready(rdy64), .req_we(r_we),
        .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wd), .rsp_valid(rspv64),
        .rsp_rdata(rdata64), .rsp_err(err64), .rsp_misalign(mis64), .busy(busy64),
        .mem_req(mreq64), .mem_we(mwe64), .mem_addr(maddr64), .mem_be(be64), .mem_wdata(mwd64),
        .mem_ack(ack64), .mem_err(m_err), .mem_rdata(m_rd));

    always #5 clock = ~clock;

    always_comb begin
        c_req  = sel ? mreq64 : mreq32;
        c_rdy  = sel ? rdy64 : rdy32;
        c_rspv = sel ? rspv64 : rspv32;
        c_busy = sel ? busy64 : busy32;
        c_we   = sel ? mwe64 : mwe32;
        c_addr = sel ? maddr64 : maddr32;
        c_be   = sel ? be64 : {4'h0, be32};
        c_wd   = sel ? mwd64 : {32'h0, mwd32};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        if (rv64 && rdy64) acc.push_back(cyc);
        cyc++;
    end

    always @(negedge clock) begin
        rsp_t e;
        if (rspv32 === 1'b1) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp32_unexpected: got rsp_valid=1 expected no response");
            end else begin
                e = q32.pop_front();
                chk("rsp32_rdata", {32'h0, rdata32}, e.rd);
                chk("rsp32_err", 64'(err32), 64'(e.err));
                chk("rsp32_misalign", 64'(mis32), 64'(e.mis));
            end
        end
    end

    always @(negedge clock) begin
        rsp_t e;
        if (rspv64 === 1'b1) begin
            if (q64.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp64_unexpected: got rsp_valid=1 expected no response");
            end else begin
                e = q64.pop_front();
                chk("rsp64_rdata", rdata64, e.rd);
                chk("rsp64_err", 64'(err64), 64'(e.err));
                chk("rsp64_misalign", 64'(mis64), 64'(e.mis));
            end
        end
    end

    task automatic issue(input logic s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [63:0] wd, input logic push, input logic [63:0] erd,
                         input logic eerr, input logic emis);
        rsp_t e;
        @(negedge clock);
        sel = s; r_we = we; r_f3 = f3; r_addr = a; r_wd = wd;
        e = '{rd: erd, err: eerr, mis: emis};
        if (s) rv64 = 1'b1; else rv32 = 1'b1;
        if (push && s) q64.push_back(e);
        if (push && !s) q32.push_back(e);
        @(negedge clock);
        rv32 = 1'b0; rv64 = 1'b0;
    endtask

    task automatic bus(input int waits, input logic [63:0] rd, input logic e, input logic [31:0] ea,
                       input logic [7:0] ebe, input logic [63:0] ewd, input logic ewe);
        chk("mem_req", 64'(c_req), 1);
        chk("mem_addr", 64'(c_addr), 64'(ea));
        chk("mem_be", 64'(c_be), 64'(ebe));
        chk("mem_we", 64'(c_we), 64'(ewe));
        if (ewe) chk("mem_wdata", c_wd, ewd);
        for (int i = 0; i < waits; i++) begin
            @(negedge clock);
            chk("mem_req_wait", 64'(c_req), 1);
            chk("mem_addr_stable", 64'(c_addr), 64'(ea));
        end
        m_rd = rd; m_err = e;
        if (sel) ack64 = 1'b1; else ack32 = 1'b1;
        @(negedge clock);
        ack32 = 1'b0; ack64 = 1'b0; m_err = 1'b0;
        chk("rsp_valid", 64'(c_rspv), 1);
        chk("mem_req_drop", 64'(c_req), 0);
        @(negedge clock);
        chk("req_ready_after", 64'(c_rdy), 1);
        chk("rsp_valid_pulse", 64'(c_rspv), 0);
    endtask

    task automatic fast();
        chk("rsp_valid_fast", 64'(c_rspv), 1);
        chk("mem_req_never", 64'(c_req), 0);
        @(negedge clock);
        chk("req_ready_fast", 64'(c_rdy), 1);
        chk("rsp_valid_fast_pulse", 64'(c_rspv), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within budget");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_ready32", 64'(rdy32), 1);
        chk("rst_busy32", 64'(busy32), 0);
        chk("rst_mreq32", 64'(mreq32), 0);
        chk("rst_maddr32", 64'(maddr32), 0);
        chk("rst_be32", 64'(be32), 0);
        chk("rst_rsp32", {rdata32, 31'h0, rspv32}, 0);
        chk("rst_ready64", 64'(rdy64), 1);
        chk("rst_mwd64", mwd64, 0);
        chk("rst_mreq64", 64'(mreq64), 0);
        @(negedge clock);
        reset = 1'b1;
        // XLEN=32, TIMEOUT=4
        issue(0, 0, 3'b000, 32'h103, 0, 1, 64'hFFFF_FF80, 0, 0);
        bus(0, 64'h8012_3456, 0, 32'h100, 8'h0F, 0, 0);
        issue(0, 1, 3'b001, 32'h202, 64'h1234_ABCD, 1, 0, 0, 0);
        bus(0, 64'hFFFF_FFFF, 0, 32'h200, 8'h0C, 64'hABCD_ABCD, 1);
        issue(0, 0, 3'b010, 32'h101, 0, 1, 0, 0, 1);
        fast();
        issue(0, 0, 3'b011, 32'h101, 0, 1, 0, 1, 0);
        fast();
        issue(0, 0, 3'b101, 32'h102, 0, 1, 64'h0000_8001, 0, 0);
        bus(0, 64'h8001_1234, 0, 32'h100, 8'h0F, 0, 0);
        issue(0, 0, 3'b001, 32'h100, 0, 1, 64'hFFFF_F00F, 0, 0);
        bus(0, 64'h0000_F00F, 0, 32'h100, 8'h0F, 0, 0);
        issue(0, 1, 3'b000, 32'h001, 64'h1234_56AB, 1, 0, 0, 0);
        bus(0, 0, 0, 32'h000, 8'h02, 64'hABAB_ABAB, 1);
        issue(0, 1, 3'b011, 32'h000, 0, 1, 0, 1, 0);
        fast();
        issue(0, 0, 3'b110, 32'h000, 0, 1, 0, 1, 0);
        fast();
        issue(0, 0, 3'b010, 32'h010, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("timeout_mem_req", 64'(mreq32), 1);
            @(negedge clock);
        end
        chk("timeout_rsp", 64'(rspv32), 1);
        chk("timeout_mem_req_drop", 64'(mreq32), 0);
        @(negedge clock);
        chk("timeout_ready", 64'(rdy32), 1);
        issue(0, 0, 3'b010, 32'h020, 0, 1, 64'h1234_5678, 0, 0);
        bus(3, 64'h1234_5678, 0, 32'h020, 8'h0F, 0, 0);
        issue(0, 1, 3'b010, 32'h030, 64'h5555_AAAA, 1, 0, 1, 0);
        bus(0, 64'h7777_7777, 1, 32'h030, 8'h0F, 64'h5555_AAAA, 1);
        issue(0, 0, 3'b010, 32'h040, 0, 0, 0, 0, 0);
        chk("mid_mem_req", 64'(mreq32), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_mem_req", 64'(mreq32), 0);
        chk("mid_rst_busy", 64'(busy32), 0);
        chk("mid_rst_ready", 64'(rdy32), 1);
        @(negedge clock);
        reset = 1'b1; ack32 = 1'b1; m_rd = 64'h1;
        @(negedge clock);
        ack32 = 1'b0;
        chk("late_ack_no_rsp", 64'(rspv32), 0);
        @(negedge clock);
        chk("late_ack_no_rsp2", 64'(rspv32), 0);
        chk("late_ack_idle", 64'(rdy32), 1);
        // XLEN=64
        issue(1, 0, 3'b011, 32'h008, 0, 1, 64'h8000_0000_0000_0001, 0, 0);
        bus(0, 64'h8000_0000_0000_0001, 0, 32'h008, 8'hFF, 0, 0);
        issue(1, 0, 3'b110, 32'h00C, 0, 1, 64'h0000_0000_8000_0001, 0, 0);
        bus(1, 64'h8000_0001_DEAD_BEEF, 0, 32'h008, 8'hFF, 0, 0);
        issue(1, 0, 3'b010, 32'h00C, 0, 1, 64'hFFFF_FFFF_8000_0001, 0, 0);
        bus(0, 64'h8000_0001_DEAD_BEEF, 0, 32'h008, 8'hFF, 0, 0);
        issue(1, 1, 3'b011, 32'h008, 64'h0102_0304_0506_0708, 1, 0, 0, 0);
        bus(0, 0, 0, 32'h008, 8'hFF, 64'h0102_0304_0506_0708, 1);
        issue(1, 1, 3'b010, 32'h004, 64'h1111_2222_CAFE_BABE, 1, 0, 0, 0);
        bus(0, 0, 0, 32'h000, 8'hF0, 64'hCAFE_BABE_CAFE_BABE, 1);
        issue(1, 1, 3'b011, 32'h004, 0, 1, 0, 0, 1);
        fast();
        issue(1, 1, 3'b100, 32'h000, 0, 1, 0, 1, 0);
        fast();
        issue(1, 0, 3'b111, 32'h000, 0, 1, 0, 1, 0);
        fast();
        @(negedge clock);
        sel = 1'b1; r_we = 1'b0; r_f3 = 3'b000; r_addr = 32'h13; m_rd = 64'h1122_3344_5566_7788; m_err = 1'b0;
        acc.delete();
        for (int i = 0; i < 3; i++) q64.push_back('{rd: 64'h55, err: 1'b0, mis: 1'b0});
        rv64 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            ack64 = mreq64;
            if (i == 6) rv64 = 1'b0;
        end
        ack64 = 1'b0;
        chk("b2b_accepts", 64'(acc.size()), 3);
        if (acc.size() >= 3) begin
            chk("b2b_gap1", 64'(acc[1] - acc[0]), 3);
            chk("b2b_gap2", 64'(acc[2] - acc[1]), 3);
        end
        @(negedge clock);
        chk("q32_drained", 64'(q32.size()), 0);
        chk("q64_drained", 64'(q64.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
